// File: rtl/soc_reset_pkg.sv
// Shared constants for the SoC reset sequencer: state codes, reset-cause codes
// and counter widths.
package soc_reset_pkg;

    localparam int CNT_W = 8;
    localparam int WDT_W = 24;

    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_HOLD      = 3'd1;
    localparam logic [2:0] ST_PERIPH    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;

    localparam logic [1:0] CAUSE_POR       = 2'd0;
    localparam logic [1:0] CAUSE_LOCK_LOSS = 2'd1;
    localparam logic [1:0] CAUSE_SOFT      = 2'd2;
    localparam logic [1:0] CAUSE_WDT       = 2'd3;

    // Event counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level (PLL lock).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_reset_sequencer.sv
// Power-on / recovery reset sequencer: qualifies PLL lock, holds both resets,
// releases the peripheral reset ahead of the CPU, and re-sequences on faults.
module soc_reset_sequencer
    import soc_reset_pkg::*;
#(
    parameter int unsigned LOCK_FILTER = 16,
    parameter int unsigned HOLD_CYCLES = 63,
    parameter int unsigned PERIPH_LEAD = 8,
    parameter int unsigned WDT_CYCLES  = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iPllLocked,
    input  logic             iSoftReset,
    input  logic             iWdtKick,
    output logic             oPeriphReset,
    output logic             oCpuReset,
    output logic             oReady,
    output logic [2:0]       oState,
    output logic [1:0]       oCause,
    output logic [CNT_W-1:0] oEventCount
);

    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST   = CNT_W'(PERIPH_LEAD - 1);
    localparam logic [WDT_W-1:0] WDT_LAST    = WDT_W'(WDT_CYCLES - 1);
    localparam bit               WDT_EN      = (WDT_CYCLES != 0);

    logic             lock_s;
    logic [2:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WDT_W-1:0] wdt, wdt_d;
    logic [1:0]       cause, cause_d;
    logic [CNT_W-1:0] events, events_d;
    logic             recover;
    logic             wdt_expire;
    logic             periph_rst, cpu_rst, ready;

    sync_2ff u_lock_sync (
        .clk   (Clock),
        .rst_n (Reset),
        .d     (iPllLocked),
        .q     (lock_s)
    );

    assign wdt_expire = WDT_EN && !iWdtKick && (wdt == WDT_LAST);

    // Recovery events are tested first, in priority order; normal progression
    // only happens when none of them fire.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        wdt_d   = '0;
        cause_d = cause;
        recover = 1'b0;
        if (state > ST_RUN) begin
            state_d = ST_WAIT_LOCK;
        end else if (state != ST_WAIT_LOCK && !lock_s) begin
            state_d = ST_WAIT_LOCK;
            cause_d = CAUSE_LOCK_LOSS;
            recover = 1'b1;
        end else if (state == ST_RUN && iSoftReset) begin
            state_d = ST_HOLD;
            cause_d = CAUSE_SOFT;
            recover = 1'b1;
        end else if (state == ST_RUN && wdt_expire) begin
            state_d = ST_HOLD;
            cause_d = CAUSE_WDT;
            recover = 1'b1;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    if (!lock_s)                 cnt_d   = '0;
                    else if (cnt == FILTER_LAST) state_d = ST_HOLD;
                    else                         cnt_d   = cnt + 1'b1;
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) state_d = ST_PERIPH;
                    else                  cnt_d   = cnt + 1'b1;
                end
                ST_PERIPH: begin
                    if (cnt == LEAD_LAST) state_d = ST_RUN;
                    else                  cnt_d   = cnt + 1'b1;
                end
                default: begin
                    if (WDT_EN && !iWdtKick) wdt_d = wdt + 1'b1;
                end
            endcase
        end
        if (state_d != state) cnt_d = '0;
        events_d = recover ? sat_inc(events) : events;
    end

    // Reset outputs are registered from the next state so they change on the
    // same edge as oState and never glitch.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_WAIT_LOCK;
            cnt        <= '0;
            wdt        <= '0;
            cause      <= CAUSE_POR;
            events     <= '0;
            periph_rst <= 1'b1;
            cpu_rst    <= 1'b1;
            ready      <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            wdt        <= wdt_d;
            cause      <= cause_d;
            events     <= events_d;
            periph_rst <= (state_d == ST_WAIT_LOCK) || (state_d == ST_HOLD);
            cpu_rst    <= (state_d != ST_RUN);
            ready      <= (state_d == ST_RUN);
        end
    end

    assign oPeriphReset = periph_rst;
    assign oCpuReset    = cpu_rst;
    assign oReady       = ready;
    assign oState       = state;
    assign oCause       = cause;
    assign oEventCount  = events;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Self-checking bench for soc_reset_sequencer: behavioural model compared every
// cycle, plus directed literal checks of the key sequencing timings.
module tb_soc_reset_sequencer;

    localparam int LOCK_FILTER = 16;
    localparam int HOLD_CYCLES = 63;
    localparam int PERIPH_LEAD = 8;
    localparam int WDT_CYCLES  = 1024;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iPllLocked = 1'b1;
    logic       iSoftReset = 1'b0;
    logic       iWdtKick = 1'b0;
    logic       oPeriphReset, oCpuReset, oReady;
    logic [2:0] oState;
    logic [1:0] oCause;
    logic [7:0] oEventCount;

    int total = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    soc_reset_sequencer #(
        .LOCK_FILTER (LOCK_FILTER),
        .HOLD_CYCLES (HOLD_CYCLES),
        .PERIPH_LEAD (PERIPH_LEAD),
        .WDT_CYCLES  (WDT_CYCLES)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iPllLocked   (iPllLocked),
        .iSoftReset   (iSoftReset),
        .iWdtKick     (iWdtKick),
        .oPeriphReset (oPeriphReset),
        .oCpuReset    (oCpuReset),
        .oReady       (oReady),
        .oState       (oState),
        .oCause       (oCause),
        .oEventCount  (oEventCount)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (oState !== target && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 16'(oState), 16'(target));
    endtask

    // Behavioural model: phase 0 wait-lock, 1 hold, 2 periph-lead, 3 run.
    int         m_phase = 0;
    int         m_count = 0;
    int         m_quiet = 0;
    int         m_cause = 0;
    int         m_events = 0;
    bit         sync_q[$] = '{1'b0, 1'b0};
    logic [15:0] exp_vec = '0;
    bit         pr_tab[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit         cr_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    task automatic enter(input int p);
        m_phase = p;
        m_count = 0;
        m_quiet = 0;
    endtask

    task automatic model_step();
        bit ls;
        bit rec;
        ls = sync_q.pop_front();
        sync_q.push_back(iPllLocked);
        rec = 1'b0;
        if (m_phase != 0 && !ls) begin
            enter(0); m_cause = 1; rec = 1'b1;
        end else if (m_phase == 3 && iSoftReset) begin
            enter(1); m_cause = 2; rec = 1'b1;
        end else if (m_phase == 3 && !iWdtKick && m_quiet + 1 == WDT_CYCLES) begin
            enter(1); m_cause = 3; rec = 1'b1;
        end else begin
            case (m_phase)
                0: begin
                    if (ls) begin
                        m_count++;
                        if (m_count == LOCK_FILTER) enter(1);
                    end else m_count = 0;
                end
                1: begin m_count++; if (m_count == HOLD_CYCLES) enter(2); end
                2: begin m_count++; if (m_count == PERIPH_LEAD) enter(3); end
                default: m_quiet = iWdtKick ? 0 : m_quiet + 1;
            endcase
        end
        if (rec && m_events < 255) m_events++;
    endtask

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            enter(0);
            m_cause  = 0;
            m_events = 0;
            sync_q   = '{1'b0, 1'b0};
        end else begin
            model_step();
        end
        exp_vec = {3'(m_phase), pr_tab[m_phase], cr_tab[m_phase], (m_phase == 3),
                   2'(m_cause), 8'(m_events)};
    end

    always @(negedge Clock) begin
        if (chk_en)
            check("cycle", {oState, oPeriphReset, oCpuReset, oReady, oCause, oEventCount}, exp_vec);
    end

    initial begin
        int drop_left;
        drop_left = 0;

        // Power-on reset with lock already high.
        tick(1);
        chk_en = 1'b1;
        tick(2);
        check("rst_state", 16'(oState), 16'd0);
        check("rst_resets", {oPeriphReset, oCpuReset, oReady}, 16'b110);
        check("rst_cause_ev", {oCause, oEventCount}, 16'd0);

        // Lock stable from release: periph at 81 edges, cpu 8 later.
        Reset = 1'b1;
        tick(80);
        check("periph_held_80", 16'(oPeriphReset), 16'd1);
        tick(1);
        check("periph_fall_81", 16'(oPeriphReset), 16'd0);
        check("cpu_held_81", 16'(oCpuReset), 16'd1);
        tick(7);
        check("cpu_held_88", 16'(oCpuReset), 16'd1);
        tick(1);
        check("cpu_fall_89", 16'(oCpuReset), 16'd0);
        check("run_ready", {oState, oReady, oCause}, {10'd0, 3'd3, 1'b1, 2'd0});

        // One-cycle lock glitch in RUN.
        iPllLocked = 1'b0;
        tick(1);
        iPllLocked = 1'b1;
        tick(2);
        check("lockloss_state", 16'(oState), 16'd0);
        check("lockloss_cause_ev", {oCause, oEventCount}, {6'd0, 2'd1, 8'd1});
        check("lockloss_resets", {oPeriphReset, oCpuReset}, 16'b11);
        wait_state(3'd3, 200, "reseq_run");

        // Soft reset on the same cycle the synchronised lock falls.
        iPllLocked = 1'b0;
        tick(2);
        iSoftReset = 1'b1;
        tick(1);
        iSoftReset = 1'b0;
        iPllLocked = 1'b1;
        check("prio_state", 16'(oState), 16'd0);
        check("prio_cause_ev", {oCause, oEventCount}, {6'd0, 2'd1, 8'd2});
        wait_state(3'd3, 200, "prio_run");

        // Soft reset alone: CPU reset held 71 cycles.
        iSoftReset = 1'b1;
        tick(1);
        iSoftReset = 1'b0;
        check("soft_state", 16'(oState), 16'd1);
        check("soft_cause_ev", {oCause, oEventCount}, {6'd0, 2'd2, 8'd3});
        tick(70);
        check("soft_cpu_held", 16'(oCpuReset), 16'd1);
        tick(1);
        check("soft_cpu_fall", {oCpuReset, oReady}, 16'b01);

        // Watchdog kicked every 1000 cycles, then starved.
        for (int k = 0; k < 3; k++) begin
            tick(999);
            iWdtKick = 1'b1;
            tick(1);
            iWdtKick = 1'b0;
        end
        check("wdt_kept_run", {oState, oEventCount}, {5'd0, 3'd3, 8'd3});
        tick(1023);
        check("wdt_1023", 16'(oState), 16'd3);
        tick(1);
        check("wdt_expire", {oState, oCause, oEventCount}, {3'd0, 3'd1, 2'd3, 8'd4});

        // Lock dropping every 10 cycles never qualifies.
        Reset = 1'b0;
        tick(2);
        Reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            iPllLocked = 1'b1;
            tick(9);
            iPllLocked = 1'b0;
            tick(1);
        end
        check("toggle_state", 16'(oState), 16'd0);
        check("toggle_resets_ev", {oPeriphReset, oCpuReset, oEventCount}, {6'd0, 2'b11, 8'd0});

        // Randomised mix of lock drops, soft resets and sparse kicks.
        iPllLocked = 1'b1;
        wait_state(3'd3, 300, "rand_start");
        for (int i = 0; i < 6000; i++) begin
            iSoftReset = ($urandom_range(0, 299) == 0);
            iWdtKick   = ($urandom_range(0, 599) == 0);
            if (drop_left > 0) begin
                iPllLocked = 1'b0;
                drop_left--;
            end else begin
                iPllLocked = 1'b1;
                if ($urandom_range(0, 399) == 0) drop_left = $urandom_range(1, 3);
            end
            tick(1);
        end
        iSoftReset = 1'b0;
        iWdtKick   = 1'b0;
        iPllLocked = 1'b1;

        // 300 soft resets saturate the event counter.
        for (int k = 0; k < 300; k++) begin
            wait_state(3'd3, 300, "soft_loop_run");
            iSoftReset = 1'b1;
            tick(1);
            iSoftReset = 1'b0;
        end
        check("event_saturate", 16'(oEventCount), 16'd255);

        // Asynchronous reset mid-PERIPH.
        wait_state(3'd2, 200, "reach_periph");
        tick(3);
        check("periph_released", {oPeriphReset, oCpuReset}, 16'b01);
        #2 Reset = 1'b0;
        #1;
        check("async_state", 16'(oState), 16'd0);
        check("async_resets", {oPeriphReset, oCpuReset, oReady}, 16'b110);
        check("async_cause_ev", {oCause, oEventCount}, 16'd0);
        tick(2);
        Reset = 1'b1;
        wait_state(3'd3, 300, "final_run");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
